// File: rtl/tens_digit_ctrl.sv
// Tens-digit stage and run-control FSM of the countdown game timer.
// Downstream of the ones-digit counter: gates its tick, blocks its wrap at 00 and flags expiry.
module tens_digit_ctrl #(
  parameter int unsigned MAX_TENS     = 9,
  parameter bit          EXPIRE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onesec_in,
  input  logic       reconfig,
  input  logic [3:0] toggle_switch,
  input  logic       start,
  input  logic       pause,
  input  logic       borrow_in,
  input  logic [3:0] ones_digit,
  output logic       tick_out,
  output logic       donot_borrow_out,
  output logic [3:0] timer_out,
  output logic       time_out,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TENS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] timer_nxt;
  logic [3:0] load_val;
  logic       both_zero;

  assign load_val  = (toggle_switch > MAX_T) ? MAX_T : toggle_switch;
  assign both_zero = (timer_out == 4'd0) && (ones_digit == 4'd0);

  assign tick_out         = onesec_in && (state == RUN);
  assign donot_borrow_out = (timer_out == 4'd0) || (state != RUN);

  // Expiry in RUN outranks pause; a borrow landing with pause still decrements.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer_out;
    if (reconfig) begin
      state_nxt = IDLE;
      timer_nxt = load_val;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (start) state_nxt = both_zero ? EXPIRED : RUN;
        end
        RUN: begin
          if (both_zero)  state_nxt = EXPIRED;
          else if (pause) state_nxt = PAUSE;
          if (borrow_in && (timer_out != 4'd0)) timer_nxt = timer_out - 4'd1;
        end
        EXPIRED: state_nxt = EXPIRED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer_out <= 4'd0;
      time_out  <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer_out <= timer_nxt;
      running   <= (state_nxt == RUN);
      if (EXPIRE_PULSE)
        time_out <= (state_nxt == EXPIRED) && (state != EXPIRED);
      else
        time_out <= (state_nxt == EXPIRED);
    end
  end

endmodule
